// File: rtl/pipelined_rca_if.sv
// Streaming bus for the pipelined ripple-carry adder: operands in, result out,
// each side with its own valid/ready pair.
interface pipelined_rca_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, cin, sub, in_valid, out_ready,
        input  in_ready, sum, cout, ovf, out_valid
    );

    modport slave (
        input  a, b, cin, sub, in_valid, out_ready,
        output in_ready, sum, cout, ovf, out_valid
    );
endinterface

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: stage k ripples CW bits and registers
// its carry; operands are skewed in and results deskewed out with one global stall.
module pipelined_rca #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input logic            clk,
    input logic            rst_n,
    pipelined_rca_if.slave bus
);
    localparam int unsigned CW = WIDTH / STAGES;

    // Each stage holds full-width operand/result words; chunks below k in the
    // operands and above k in the result are unused and trimmed by synthesis.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];
    logic             ovf_d;
    logic             carry;
    logic             carry_new;
    logic             carry_msb_in;
    logic             adv;

    assign adv = !v_q[STAGES-1] || bus.out_ready;

    always_comb begin
        ovf_d        = 1'b0;
        carry        = 1'b0;
        carry_new    = 1'b0;
        carry_msb_in = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            // Subtract is resolved at capture so later stages only ever add.
            if (k == 0) begin
                a_d[k] = bus.a;
                b_d[k] = bus.sub ? ~bus.b : bus.b;
                s_d[k] = '0;
                carry  = bus.sub ? ~bus.cin : bus.cin;
            end else begin
                a_d[k] = a_q[(k == 0) ? 0 : k - 1];
                b_d[k] = b_q[(k == 0) ? 0 : k - 1];
                s_d[k] = s_q[(k == 0) ? 0 : k - 1];
                carry  = c_q[(k == 0) ? 0 : k - 1];
            end
            for (int unsigned i = 0; i < CW; i++) begin
                s_d[k][k*CW+i] = a_d[k][k*CW+i] ^ b_d[k][k*CW+i] ^ carry;
                carry_new      = (a_d[k][k*CW+i] & b_d[k][k*CW+i]) |
                                 (a_d[k][k*CW+i] & carry) |
                                 (b_d[k][k*CW+i] & carry);
                carry_msb_in   = carry;
                carry          = carry_new;
            end
            c_d[k] = carry;
            if (k == STAGES - 1) begin
                ovf_d = carry_msb_in ^ carry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                v_q[k] <= (k == 0) ? bus.in_valid : v_q[(k == 0) ? 0 : k - 1];
            end
            ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = v_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_rca.sv
// Scoreboard bench for pipelined_rca: directed vectors, async reset mid-stream,
// a backpressured random stream, and a (WIDTH, STAGES) sweep.
module tb_pipelined_rca;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;
    logic lat_chk = 1'b0;
    logic seen = 1'b0;
    logic sweep_go = 1'b0;
    logic stream_done = 1'b0;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_rca_if #(.WIDTH(16)) bus ();

    pipelined_rca #(.WIDTH(16), .STAGES(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bb;
        logic [16:0] full;
        logic        ov;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'b0, (sub ? ~cin : cin)};
        ov   = (a[15] == bb[15]) && (full[15] != a[15]);
        return {ov, full[16], full[15:0]};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input logic [15:0] es, input logic ec,
                         input logic eo);
        exp_t e;
        logic done;
        done        = 1'b0;
        bus.a       = a;
        bus.b       = b;
        bus.cin     = cin;
        bus.sub     = sub;
        bus.in_valid = 1'b1;
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        for (int t = 0; t < 200 && !done; t++) begin
            @(posedge clk);
            if (bus.in_ready) begin
                e.acc = cyc;
                q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) chk("issue_timeout", 0, 1);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && q.size() != 0; t++) step();
        chk("drain_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    chk("result", {bus.ovf, bus.cout, bus.sum},
                        {q[0].ovf, q[0].cout, q[0].sum});
                    if (lat_chk && !seen) chk("latency", cyc - q[0].acc, 4);
                    seen = 1'b1;
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int unsigned W = (g == 2) ? 32 : 4;
        localparam int unsigned S = (g == 0) ? 1 : (g == 1) ? 4 : 8;
        localparam logic [W-1:0] ONES = '1;
        localparam logic [W-1:0] MAXP = ONES >> 1;
        localparam logic [W-1:0] MINN = ~MAXP;

        pipelined_rca_if #(.WIDTH(W)) sbus ();

        pipelined_rca #(.WIDTH(W), .STAGES(S)) sdut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (sbus)
        );

        logic [W-1:0] qs[$];
        logic         qc[$];
        logic         qo[$];
        int           qa[$];
        logic [W-1:0] va[6], vb[6], vs[6];
        logic         vc[6], vsub[6], vco[6], vov[6];

        always @(negedge clk) begin
            if (rst_n && sbus.out_valid) begin
                if (qs.size() == 0) begin
                    chk($sformatf("sw%0d_unexpected", g), 1, 0);
                end else begin
                    chk($sformatf("sw%0d_result", g), {sbus.ovf, sbus.cout, sbus.sum},
                        {qo[0], qc[0], qs[0]});
                    chk($sformatf("sw%0d_latency", g), cyc - qa[0], S);
                    void'(qs.pop_front());
                    void'(qc.pop_front());
                    void'(qo.pop_front());
                    void'(qa.pop_front());
                end
            end
        end

        initial begin
            // ripple: ones+1, maxpos+1, ones+ones+1; subtract: 5-7, 7-5-1, minneg-1
            va[0] = ONES;   vb[0] = W'(1); vc[0] = 1'b0; vsub[0] = 1'b0;
            vs[0] = '0;     vco[0] = 1'b1; vov[0] = 1'b0;
            va[1] = MAXP;   vb[1] = W'(1); vc[1] = 1'b0; vsub[1] = 1'b0;
            vs[1] = MINN;   vco[1] = 1'b0; vov[1] = 1'b1;
            va[2] = ONES;   vb[2] = ONES;  vc[2] = 1'b1; vsub[2] = 1'b0;
            vs[2] = ONES;   vco[2] = 1'b1; vov[2] = 1'b0;
            va[3] = W'(5);  vb[3] = W'(7); vc[3] = 1'b0; vsub[3] = 1'b1;
            vs[3] = ONES - W'(1); vco[3] = 1'b0; vov[3] = 1'b0;
            va[4] = W'(7);  vb[4] = W'(5); vc[4] = 1'b1; vsub[4] = 1'b1;
            vs[4] = W'(1);  vco[4] = 1'b1; vov[4] = 1'b0;
            va[5] = MINN;   vb[5] = W'(1); vc[5] = 1'b0; vsub[5] = 1'b1;
            vs[5] = MAXP;   vco[5] = 1'b1; vov[5] = 1'b1;
            sbus.a = '0; sbus.b = '0; sbus.cin = 1'b0; sbus.sub = 1'b0;
            sbus.in_valid = 1'b0;
            sbus.out_ready = 1'b1;
            wait (sweep_go);
            @(posedge clk);
            #1;
            for (int i = 0; i < 6; i++) begin
                sbus.a = va[i]; sbus.b = vb[i]; sbus.cin = vc[i]; sbus.sub = vsub[i];
                sbus.in_valid = 1'b1;
                @(posedge clk);
                chk($sformatf("sw%0d_accept", g), sbus.in_ready, 1);
                if (sbus.in_ready) begin
                    qs.push_back(vs[i]); qc.push_back(vco[i]);
                    qo.push_back(vov[i]); qa.push_back(cyc);
                end
                #1;
            end
            sbus.in_valid = 1'b0;
            repeat (S + 4) @(posedge clk);
            chk($sformatf("sw%0d_drained", g), qs.size(), 0);
        end
    end

    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [17:0] m;

    initial begin
        rst_n = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_in_ready_or0", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        #1;
        chk("rst_in_ready_or1", bus.in_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;
        lat_chk = 1'b1;

        // Directed arithmetic, back to back, no stall.
        issue(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        issue(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        drain();

        // Fill the pipe under stall, then reset asynchronously mid-cycle.
        bus.out_ready = 1'b0;
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        issue(16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0);
        issue(16'h1111, 16'h1111, 1'b1, 1'b0, 16'h2223, 1'b0, 1'b0);
        step();
        step();
        chk("stall_out_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_sum", bus.sum, 0);
        chk("midrst_cout", bus.cout, 0);
        chk("midrst_ovf", bus.ovf, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        q.delete();
        seen = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("post_rst_idle", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        drain();

        // Random stream with pseudo-random backpressure.
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    m  = model(ra, rb, rc, rs);
                    issue(ra, rb, rc, rs, m[15:0], m[16], m[17]);
                end
                drain();
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;

        sweep_go = 1'b1;
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
